maj_net_sequencer: RTL and testbench
====================================

# maj_net_sequencer

Time-multiplexed evaluator for small majority-inverter networks over six primary inputs. A node program is loaded into an internal register file. Each accepted input vector is then evaluated one node per cycle through a single shared 3-input majority unit, with optional complement on each operand, and one selected node value is returned as the single output. It sits between an input-vector source and a result consumer, and lets one hardware resource evaluate any stored function netlist of up to MAX_NODES gates.

## Interface
- NUM_IN, 6, number of primary inputs
- MAX_NODES, 16, node program depth
- IDX_W, 5, operand index width; index space 0 = const0, 1..NUM_IN = x[0..NUM_IN-1], NUM_IN+1..NUM_IN+MAX_NODES = node 0..MAX_NODES-1
- AW, 4, prog_addr width (clog2 MAX_NODES)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- prog_we  in  1  program write strobe; honoured only in IDLE
- prog_addr  in  AW  node number to write
- prog_data  in  3*(IDX_W+1)  {opC,opB,opA}; each op = {inv, idx[IDX_W-1:0]}
- num_nodes  in  AW+1  nodes to evaluate, 0..MAX_NODES; sampled at accept
- out_sel  in  IDX_W+1  {inv, idx} of the result operand; sampled at accept
- in_valid  in  1  input vector valid
- in_ready  out  1  high in IDLE only
- x  in  NUM_IN  input vector
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- y  out  1  result
- err  out  1  sticky illegal-reference flag, cleared on accept

## Operation
- States: IDLE, EVAL, HOLD.
- IDLE: in_ready=1. On in_valid&in_ready the block:
  - latches x, num_nodes and out_sel;
  - clears the node-value register and err;
  - sets ptr=0;
  - goes to EVAL, or to HOLD if num_nodes==0.
- EVAL: each cycle the block:
  - reads the three operands of node ptr;
  - computes v = maj(a^invA, b^invB, c^invC);
  - writes v to node-value bit ptr and increments ptr;
  - goes to HOLD after the cycle with ptr==num_nodes-1.
- Operand resolution:
  - idx 0 → 0.
  - idx 1..NUM_IN → latched x[idx-1].
  - idx ≥ NUM_IN+1 → node value (idx-NUM_IN-1), legal only if that node number < ptr.
  - A node number ≥ ptr, or an idx beyond NUM_IN+MAX_NODES, is illegal: the operand reads 0 (before inv) and err is set.
  - out_sel is resolved the same way with ptr=num_nodes.
- HOLD:
  - out_valid=1; y = resolved out_sel value ^ out_sel.inv, stable while out_valid=1.
  - On out_ready, return to IDLE.
- Program writes:
  - In IDLE, prog_we writes prog_data to node prog_addr.
  - Writes with prog_addr ≥ MAX_NODES, or outside IDLE, are ignored.
  - A write and an accept in the same cycle: the write lands first. The evaluation uses the new word only if it is read in a later cycle, which is always true.
- num_nodes > MAX_NODES is clamped to MAX_NODES.

## Timing
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, y=0, err=0, ptr=0, node values=0, program words=0.
- Latency: out_valid rises num_nodes+1 cycles after the accept edge; with num_nodes=0 it rises 1 cycle after.
- Throughput: one vector per num_nodes+2 cycles when out_ready is held high (HOLD→IDLE costs 1 cycle).
- Deasserting rst_n mid-EVAL discards the evaluation; no out_valid is produced for that vector.
- err is set in the cycle after the offending read, stays until the next accept, and is valid together with out_valid.

## Configuration
- MAJ_SEQ_CHECK_EN defined: illegal-reference detection as described; err is live.
- MAJ_SEQ_CHECK_EN undefined: no range or ordering check; err is tied 0.
  - An out-of-range idx reads 0.
  - A forward node reference reads the current node-value bit, which is 0 after the clear at accept.
  - All other behaviour is identical.

## Test plan
- Reset mid-EVAL (num_nodes=8, assert rst_n low at cycle 3) → in_ready=1, out_valid=0, y=0, err=0; the next vector evaluates correctly.
- Node0=maj(x0,x1,~x2) (ops 1,2,inv|3), num_nodes=1, out_sel=7, x=6'b000011 → out_valid 2 cycles after accept, y=1. With x=6'b000100 → y=0.
- AND/OR chain:
  - node0 = maj(x3,x4,0); node1 = maj(x3,x5,~0); node2 = maj(~node0,node1,x4).
  - num_nodes=3, out_sel=9.
  - Sweep all 64 x → y matches the software model. Latency is 4 cycles each.
- Backpressure: hold out_ready=0 for 10 cycles → y stable, in_ready=0, and in_valid pulses are not accepted. out_ready=1 → IDLE next cycle.
- Forward reference: node0 opA idx=8 with num_nodes=2 → err=1 at out_valid, operand treated as 0. Rebuild without MAJ_SEQ_CHECK_EN → err=0, same y.
- Write during EVAL to node0 → ignored; the next evaluation uses the old word. num_nodes=0, out_sel=inv|0 → y=1 one cycle after accept.

Source files
------------

// File: rtl/maj_net_sequencer_if.sv
`timescale 1ns/1ps
// Handshake and program bus for maj_net_sequencer: source/consumer side is master, evaluator is slave.
interface maj_net_sequencer_if #(
  parameter int unsigned NUM_IN = 6,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned AW     = 4
) ();
  logic                      prog_we;
  logic [AW-1:0]             prog_addr;
  logic [3*(IDX_W+1)-1:0]    prog_data;
  logic [AW:0]               num_nodes;
  logic [IDX_W:0]            out_sel;
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_IN-1:0]         x;
  logic                      out_valid;
  logic                      out_ready;
  logic                      y;
  logic                      err;

  modport master (
    output prog_we, prog_addr, prog_data, num_nodes, out_sel, in_valid, x, out_ready,
    input  in_ready, out_valid, y, err
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, num_nodes, out_sel, in_valid, x, out_ready,
    output in_ready, out_valid, y, err
  );
endinterface

// File: rtl/maj_net_sequencer.sv
`timescale 1ns/1ps
// Time-multiplexed majority-inverter network evaluator: one stored node per cycle through a shared MAJ3.
// Optional feature macro MAJ_SEQ_CHECK_EN: illegal-reference detection drives err (otherwise err stays 0).
module maj_net_sequencer #(
  parameter int unsigned NUM_IN    = 6,
  parameter int unsigned MAX_NODES = 16,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned AW        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  maj_net_sequencer_if.slave  bus
);

  localparam int unsigned OP_W   = IDX_W + 1;
  localparam int unsigned WORD_W = 3 * OP_W;
  localparam int unsigned PW     = AW + 1;
`ifdef MAJ_SEQ_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_HOLD} state_t;

  state_t              r_state;
  logic [WORD_W-1:0]   r_prog [MAX_NODES];
  logic [MAX_NODES-1:0] r_nodes;
  logic [NUM_IN-1:0]   r_x;
  logic [PW-1:0]       r_num;
  logic [OP_W-1:0]     r_osel;
  logic [PW-1:0]       r_ptr;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_y;
  logic                r_err;

  // Returns {illegal, value^inv}; node refs at or beyond lim are forward references.
  function automatic logic [1:0] resolve(
    input logic [OP_W-1:0]      op,
    input logic [NUM_IN-1:0]    xv,
    input logic [MAX_NODES-1:0] nv,
    input logic [PW-1:0]        lim
  );
    int unsigned          idx;
    int unsigned          node;
    logic [NUM_IN-1:0]    xs;
    logic [MAX_NODES-1:0] ns;
    logic                 val;
    logic                 bad;
    idx  = 32'(op[IDX_W-1:0]);
    node = 0;
    xs   = '0;
    ns   = '0;
    val  = 1'b0;
    bad  = 1'b0;
    if (idx == 0) begin
      val = 1'b0;
    end else if (idx <= NUM_IN) begin
      xs  = xv >> (idx - 1);
      val = xs[0];
    end else begin
      node = idx - NUM_IN - 1;
      if (node >= MAX_NODES) begin
        bad = 1'b1;
      end else begin
        ns  = nv >> node;
        val = ns[0];
        if (CHECK_EN && (node >= 32'(lim))) begin
          val = 1'b0;
          bad = 1'b1;
        end
      end
    end
    return {bad, val ^ op[IDX_W]};
  endfunction

  logic [WORD_W-1:0]    w_word;
  logic [1:0]           w_a, w_b, w_c;
  logic                 w_v;
  logic                 w_op_err;
  logic [MAX_NODES-1:0] w_nodes_nxt;
  logic [PW-1:0]        w_num_clamp;
  logic [1:0]           w_res_eval;
  logic [1:0]           w_res_zero;
  logic                 w_last;
  logic                 w_prog_ok;

  assign w_word      = r_prog[r_ptr[AW-1:0]];
  assign w_a         = resolve(w_word[OP_W-1:0],        r_x, r_nodes, r_ptr);
  assign w_b         = resolve(w_word[2*OP_W-1:OP_W],   r_x, r_nodes, r_ptr);
  assign w_c         = resolve(w_word[3*OP_W-1:2*OP_W], r_x, r_nodes, r_ptr);
  assign w_v         = (w_a[0] & w_b[0]) | (w_a[0] & w_c[0]) | (w_b[0] & w_c[0]);
  assign w_op_err    = CHECK_EN & (w_a[1] | w_b[1] | w_c[1]);
  assign w_nodes_nxt = r_nodes | (MAX_NODES'(w_v) << r_ptr);
  assign w_num_clamp = (bus.num_nodes > PW'(MAX_NODES)) ? PW'(MAX_NODES) : bus.num_nodes;
  // Result resolves against the node vector including the value written this cycle.
  assign w_res_eval  = resolve(r_osel, r_x, w_nodes_nxt, r_num);
  assign w_res_zero  = resolve(bus.out_sel, bus.x, '0, '0);
  assign w_last      = (r_ptr == (r_num - PW'(1)));
  assign w_prog_ok   = ({1'b0, bus.prog_addr} < PW'(MAX_NODES));

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.y         = r_y;
  assign bus.err       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_nodes     <= '0;
      r_x         <= '0;
      r_num       <= '0;
      r_osel      <= '0;
      r_ptr       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_y         <= 1'b0;
      r_err       <= 1'b0;
      for (int i = 0; i < int'(MAX_NODES); i++) r_prog[i] <= '0;
    end else begin
      if ((r_state == S_IDLE) && bus.prog_we && w_prog_ok)
        r_prog[bus.prog_addr] <= bus.prog_data;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_x        <= bus.x;
            r_num      <= w_num_clamp;
            r_osel     <= bus.out_sel;
            r_nodes    <= '0;
            r_ptr      <= '0;
            r_in_ready <= 1'b0;
            if (w_num_clamp == '0) begin
              r_state     <= S_HOLD;
              r_out_valid <= 1'b1;
              r_y         <= w_res_zero[0];
              r_err       <= CHECK_EN & w_res_zero[1];
            end else begin
              r_state <= S_EVAL;
              r_err   <= 1'b0;
            end
          end
        end
        S_EVAL: begin
          r_nodes <= w_nodes_nxt;
          r_ptr   <= r_ptr + PW'(1);
          if (w_op_err) r_err <= 1'b1;
          if (w_last) begin
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
            r_y         <= w_res_eval[0];
            if (CHECK_EN && w_res_eval[1]) r_err <= 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maj_net_sequencer.sv
`timescale 1ns/1ps
// Directed self-checking bench for maj_net_sequencer (honours MAJ_SEQ_CHECK_EN for err expectations).
module tb_maj_net_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

`ifdef MAJ_SEQ_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  maj_net_sequencer_if bus ();

  maj_net_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [5:0] op(input logic inv, input int unsigned idx);
    return {inv, 5'(idx)};
  endfunction

  function automatic logic [17:0] word(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    return {c, b, a};
  endfunction

  function automatic logic chain_model(input logic [5:0] xv);
    logic n0, n1, a;
    n0 = xv[3] & xv[4];
    n1 = xv[3] | xv[5];
    a  = ~n0;
    return (a & n1) | (a & xv[4]) | (n1 & xv[4]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [3:0] addr, input logic [17:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = d;
    step();
    bus.prog_we   = 1'b0;
  endtask

  task automatic prog_chain();
    prog(4'd0, word(op(0, 4), op(0, 5), op(0, 0)));
    prog(4'd1, word(op(0, 4), op(0, 6), op(1, 0)));
    prog(4'd2, word(op(1, 7), op(0, 8), op(0, 5)));
  endtask

  // Accepts one vector and waits (bounded) for out_valid; lat counts cycles from the accept cycle.
  task automatic start_vec(input logic [5:0] xv, input logic [4:0] n, input logic [5:0] osel, output int lat);
    int g;
    g = 0;
    while (!bus.in_ready && g < 50) begin step(); g++; end
    bus.x         = xv;
    bus.num_nodes = n;
    bus.out_sel   = osel;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin step(); lat++; end
  endtask

  task automatic end_vec();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input logic [5:0] xv, input logic [4:0] n, input logic [5:0] osel,
                         output int lat, output logic yv, output logic ev);
    start_vec(xv, n, osel, lat);
    yv = bus.y;
    ev = bus.err;
    end_vec();
  endtask

  task automatic test_reset();
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.num_nodes = '0; bus.out_sel = '0; bus.in_valid = 1'b0;
    bus.x = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.y !== 1'b0) $display("FAIL reset_y: got %b want 0", bus.y); else n_pass++;
    n_checks++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_simple_maj();
    int lat; logic yv, ev;
    prog(4'd0, word(op(0, 1), op(0, 2), op(1, 3)));
    run_vec(6'b000011, 5'd1, 6'd7, lat, yv, ev);
    n_checks++; if (yv !== 1'b1) $display("FAIL simple_y_000011: got %b want 1", yv); else n_pass++;
    n_checks++; if (lat != 2) $display("FAIL simple_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (ev !== 1'b0) $display("FAIL simple_err: got %b want 0", ev); else n_pass++;
    run_vec(6'b000100, 5'd1, 6'd7, lat, yv, ev);
    n_checks++; if (yv !== 1'b0) $display("FAIL simple_y_000100: got %b want 0", yv); else n_pass++;
  endtask

  task automatic test_and_or_chain();
    int lat; logic yv, ev, exp_y;
    prog_chain();
    for (int i = 0; i < 64; i++) begin
      run_vec(6'(i), 5'd3, 6'd9, lat, yv, ev);
      exp_y = chain_model(6'(i));
      n_checks++; if (yv !== exp_y) $display("FAIL chain_y x=%0d: got %b want %b", i, yv, exp_y); else n_pass++;
      n_checks++; if (lat != 4) $display("FAIL chain_latency x=%0d: got %0d want 4", i, lat); else n_pass++;
      n_checks++; if (ev !== 1'b0) $display("FAIL chain_err x=%0d: got %b want 0", i, ev); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int lat, bad; logic y0;
    start_vec(6'b111000, 5'd3, 6'd9, lat);
    y0 = bus.y;
    n_checks++; if (y0 !== 1'b1) $display("FAIL bp_y: got %b want 1", y0); else n_pass++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.x        = 6'(i);
      step();
      if (bus.y !== y0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
    end
    bus.in_valid = 1'b0;
    n_checks++; if (bad != 0) $display("FAIL bp_hold_cycles: got %0d bad cycles want 0", bad); else n_pass++;
    end_vec();
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_release_out_valid: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_write_during_eval();
    int lat, g; logic yv, ev;
    prog_chain();
    bus.x = 6'b010000; bus.num_nodes = 5'd3; bus.out_sel = 6'd9; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = word(op(1, 0), op(1, 0), op(1, 0));
    step();
    bus.prog_we = 1'b0;
    g = 0;
    while (!bus.out_valid && g < 100) begin step(); g++; end
    n_checks++; if (bus.y !== 1'b1) $display("FAIL wde_first_y: got %b want 1", bus.y); else n_pass++;
    end_vec();
    run_vec(6'b010000, 5'd3, 6'd9, lat, yv, ev);
    n_checks++; if (yv !== 1'b1) $display("FAIL wde_old_word_y: got %b want 1", yv); else n_pass++;
    run_vec(6'b000000, 5'd0, op(1, 0), lat, yv, ev);
    n_checks++; if (yv !== 1'b1) $display("FAIL zero_nodes_y: got %b want 1", yv); else n_pass++;
    n_checks++; if (lat != 1) $display("FAIL zero_nodes_latency: got %0d want 1", lat); else n_pass++;
    // Write and accept in the same cycle: the new node0 (const 1) is used.
    bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = word(op(1, 0), op(1, 0), op(1, 0));
    start_vec(6'b010000, 5'd3, 6'd9, lat);
    bus.prog_we = 1'b0;
    n_checks++; if (bus.y !== 1'b0) $display("FAIL same_cycle_write_y: got %b want 0", bus.y); else n_pass++;
    end_vec();
  endtask

  task automatic test_clamp();
    int lat; logic yv, ev;
    prog_chain();
    run_vec(6'b010000, 5'd31, 6'd9, lat, yv, ev);
    n_checks++; if (yv !== 1'b1) $display("FAIL clamp_y: got %b want 1", yv); else n_pass++;
    n_checks++; if (lat != 17) $display("FAIL clamp_latency: got %0d want 17", lat); else n_pass++;
  endtask

  task automatic test_forward_ref();
    int lat; logic yv, ev;
    prog(4'd0, word(op(0, 8), op(0, 1), op(0, 2)));
    prog(4'd1, word(op(0, 7), op(0, 7), op(0, 0)));
    run_vec(6'b000011, 5'd2, 6'd8, lat, yv, ev);
    n_checks++; if (yv !== 1'b1) $display("FAIL fwd_y_000011: got %b want 1", yv); else n_pass++;
    n_checks++; if (ev !== EXP_ERR) $display("FAIL fwd_err: got %b want %b", ev, EXP_ERR); else n_pass++;
    n_checks++; if (lat != 3) $display("FAIL fwd_latency: got %0d want 3", lat); else n_pass++;
    run_vec(6'b000010, 5'd2, 6'd8, lat, yv, ev);
    n_checks++; if (yv !== 1'b0) $display("FAIL fwd_y_000010: got %b want 0", yv); else n_pass++;
    run_vec(6'b111111, 5'd0, op(0, 30), lat, yv, ev);
    n_checks++; if (yv !== 1'b0) $display("FAIL oor_sel_y: got %b want 0", yv); else n_pass++;
    n_checks++; if (ev !== EXP_ERR) $display("FAIL oor_sel_err: got %b want %b", ev, EXP_ERR); else n_pass++;
    run_vec(6'b111111, 5'd0, op(1, 30), lat, yv, ev);
    n_checks++; if (yv !== 1'b1) $display("FAIL oor_sel_inv_y: got %b want 1", yv); else n_pass++;
    run_vec(6'b000001, 5'd0, op(0, 1), lat, yv, ev);
    n_checks++; if (yv !== 1'b1) $display("FAIL err_clear_y: got %b want 1", yv); else n_pass++;
    n_checks++; if (ev !== 1'b0) $display("FAIL err_clear_err: got %b want 0", ev); else n_pass++;
  endtask

  task automatic test_reset_mid_eval();
    int lat, seen; logic yv, ev;
    prog_chain();
    bus.x = 6'b111000; bus.num_nodes = 5'd8; bus.out_sel = 6'd9; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rme_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rme_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.y !== 1'b0) $display("FAIL rme_y: got %b want 0", bus.y); else n_pass++;
    n_checks++; if (bus.err !== 1'b0) $display("FAIL rme_err: got %b want 0", bus.err); else n_pass++;
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin step(); if (bus.out_valid) seen++; end
    n_checks++; if (seen != 0) $display("FAIL rme_no_out_valid: got %0d valid cycles want 0", seen); else n_pass++;
    // Program words were cleared: all nodes evaluate maj(0,0,0)=0.
    run_vec(6'b010000, 5'd3, 6'd9, lat, yv, ev);
    n_checks++; if (yv !== 1'b0) $display("FAIL rme_cleared_prog_y: got %b want 0", yv); else n_pass++;
    prog_chain();
    run_vec(6'b010000, 5'd3, 6'd9, lat, yv, ev);
    n_checks++; if (yv !== 1'b1) $display("FAIL rme_next_vec_y: got %b want 1", yv); else n_pass++;
    n_checks++; if (lat != 4) $display("FAIL rme_next_vec_latency: got %0d want 4", lat); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_simple_maj();
    test_and_or_chain();
    test_backpressure();
    test_write_during_eval();
    test_clamp();
    test_forward_ref();
    test_reset_mid_eval();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
